mem2apb_bridge: RTL and testbench
=================================

# mem2apb_bridge

Protocol bridge between the core's request/grant/rvalid data port and the peripheral APB subsystem. It serialises one core access at a time into a standard two-phase APB transfer (SETUP, ACCESS) and drives the APB slave port of the peripheral bus wrapper. The peripheral bus then decodes the address and forwards the transfer to UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC control or debug. Each core access receives exactly one response pulse carrying read data and an error flag.

## Interface
- APB_ADDR_WIDTH, 32: width of the APB address.
- APB_DATA_WIDTH, 32: width of the APB data; the core data port uses the same width.
- TIMEOUT_CYCLES, 255: maximum number of ACCESS cycles without PREADY before the transfer is aborted. Used only with the timeout feature (see Configuration).
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  grant; the request is accepted in the cycle where data_req_i and data_gnt_o are both high.
- data_addr_i  in  APB_ADDR_WIDTH  byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  APB_DATA_WIDTH  write data.
- data_rvalid_o  out  1  one-cycle response pulse.
- data_rdata_o  out  APB_DATA_WIDTH  read data.
- data_err_o  out  1  error flag, valid while data_rvalid_o is high.
- apb_master  APB_BUS.Master  APB_ADDR_WIDTH/APB_DATA_WIDTH  carries paddr, pwdata, pwrite, psel, penable (outputs) and prdata, pready, pslverr (inputs).

## Operation
- State machine states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - data_gnt_o = data_req_i (combinational). No other state ever grants.
  - On an accepted request, register the following:
    - paddr = {addr[APB_ADDR_WIDTH-1:2], 2'b00}
    - pwrite = data_we_i
    - pwdata = data_wdata_i
  - Next state is SETUP.
  - A write with data_be_i != 4'b1111 is rejected. APB has no strobes, so no APB transfer occurs; the pending error flag is set and the next state is RESP.
- **SETUP**: psel=1, penable=0 for exactly one cycle. Next state is ACCESS.
- **ACCESS**: psel=1, penable=1.
  - When pready=1, capture the response:
    - data_rdata_o = pwrite ? 0 : prdata
    - error flag = pslverr
  - Next state is RESP.
  - Address, write data and pwrite stay stable from SETUP through the end of ACCESS.
- **RESP**: data_rvalid_o=1 for one cycle, with data_err_o = error flag. Next state is IDLE.
- data_rdata_o is registered and holds its value until the next response.
- data_rdata_o is 0 on writes, rejected writes and timeouts.
- psel and penable are 0 in IDLE and RESP.
- pready and pslverr are ignored outside ACCESS.
- A new request arriving in any state other than IDLE waits; it is granted only in IDLE.

## Timing
- Reset values:
  - State: IDLE.
  - psel, penable, pwrite: 0.
  - paddr, pwdata: 0.
  - data_rvalid_o, data_err_o: 0.
  - data_rdata_o: 0.
  - Timeout counter: 0.
- Reset asserted mid-transfer drops psel/penable immediately (asynchronously). No response is issued for the interrupted access.
- Latency with a zero-wait-state slave, where cycle 0 is the grant cycle:
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS, with pready=1.
  - Cycle 3: data_rvalid_o.
- Each wait state in ACCESS adds one cycle.
- A rejected write gives data_rvalid_o in cycle 1 with data_err_o=1.
- Back-to-back throughput: the next grant is possible in the cycle after RESP. Minimum spacing between grants is 4 cycles.

## Configuration
- Macro: MEM2APB_TIMEOUT_EN.
- **Defined**:
  - An 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES with pready still 0, the bridge aborts:
    - psel and penable drop in the next cycle.
    - State goes to RESP with data_err_o=1 and data_rdata_o=0.
  - pready=1 in the same cycle the limit is reached counts as a normal completion.
- **Not defined**: no counter exists, and ACCESS waits indefinitely for pready.

## Test plan
- Read at 0x1A10_1004 (GPIO region), slave has pready=1 immediately and prdata=0xDEAD_BEEF:
  - gnt in cycle 0; psel=1/penable=0 in cycle 1; penable=1 in cycle 2; rvalid in cycle 3.
  - Response: rdata=0xDEAD_BEEF, err=0.
- Write 0x0000_00A5 to 0x1A10_0003, be=4'hF, slave inserts 3 wait states:
  - paddr=0x1A10_0000, pwrite=1, pwdata stable across 4 ACCESS cycles.
  - rvalid in cycle 6, rdata=0, err=0.
- Write with be=4'b0011: no psel at all; rvalid in cycle 1 with err=1.
- Read where the slave returns pslverr=1 and prdata=0x1234: rvalid with err=1, rdata=0x1234.
- With MEM2APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, and pready held at 0:
  - psel deasserts after 4 ACCESS cycles; rvalid follows with err=1, rdata=0.
  - A following request is granted normally.
- Request held high continuously, plus rst_ni pulsed low during ACCESS:
  - While holding: grants are spaced exactly 4 cycles apart.
  - Reset pulse: psel/penable drop in the same cycle; no rvalid for the aborted access; a fresh grant follows after release.

Source files
------------

// File: rtl/mem2apb_bridge_if.sv
// APB bus bundle: the bridge drives it through the Master modport and the peripheral bus wrapper
// attaches through the Slave modport.
interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/mem2apb_bridge.sv
// Core data port (req/gnt/rvalid) to APB master bridge, one access in flight at a time.
// Optional ACCESS timeout abort enabled by defining MEM2APB_TIMEOUT_EN.
module mem2apb_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
  output logic                      data_err_o,
  APB_BUS.Master                    apb_master
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                    state_q, state_d;
  logic                      accept, reject, done, abort;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic                      psel, penable;
  logic                      unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign accept = (state_q == IDLE) && data_req_i;
  // APB has no byte strobes, so partial writes cannot be forwarded
  assign reject = data_we_i && (data_be_i != 4'hF);
  assign done   = (state_q == ACCESS) && apb_master.pready;

`ifdef MEM2APB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;

  // Abort on the wait cycle that would bring the count up to the limit
  assign abort = (state_q == ACCESS) && !apb_master.pready &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !apb_master.pready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT_CYCLES);
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_req_i) state_d = reject ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done || abort) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_gnt_o    = (state_q == IDLE) && data_req_i;
    psel          = (state_q == SETUP) || (state_q == ACCESS);
    penable       = (state_q == ACCESS);
    data_rvalid_o = (state_q == RESP);
    data_err_o    = (state_q == RESP) && err_q;
  end

  // Request capture on grant; response capture on completion, reject or abort
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      paddr_q  <= {data_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
      pwdata_q <= data_wdata_i;
      pwrite_q <= data_we_i;
      if (reject) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end else if (done) begin
      rdata_q <= pwrite_q ? '0 : apb_master.prdata;
      err_q   <= apb_master.pslverr;
    end else if (abort) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign data_rdata_o       = rdata_q;
  assign apb_master.paddr   = paddr_q;
  assign apb_master.pwdata  = pwdata_q;
  assign apb_master.pwrite  = pwrite_q;
  assign apb_master.psel    = psel;
  assign apb_master.penable = penable;

endmodule

// File: tb/tb_mem2apb_bridge.sv
// Self-checking bench for mem2apb_bridge: directed plan cases, randomized transactions against a
// cycle-level transaction model, back-to-back grants, mid-transfer reset and (optionally) timeout.
module tb_mem2apb_bridge;

  localparam int TO = 4;
`ifdef MEM2APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req, gnt, we, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [31:0] prdata;
  logic        pready, pslverr;
  int          errors, checks;

  APB_BUS #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb ();
  assign apb.prdata  = prdata;
  assign apb.pready  = pready;
  assign apb.pslverr = pslverr;

  mem2apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_req_i   (req),
    .data_gnt_o   (gnt),
    .data_addr_i  (addr),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_wdata_i (wdata),
    .data_rvalid_o(rvalid),
    .data_rdata_o (rdata),
    .data_err_o   (err),
    .apb_master   (apb.Master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One core access; expectations come from the transaction-level timing rules.
  task automatic do_txn(input string name, input logic t_we, input logic [3:0] t_be,
                        input logic [31:0] t_addr, input logic [31:0] t_wdata, input int waits,
                        input logic t_slverr, input logic [31:0] t_sdata);
    bit          rej, abort, fin;
    int          n_acc, rv_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [2:0]  exp_ctl, got_ctl;
    rej       = t_we && (t_be != 4'hF);
    abort     = TO_EN && !rej && (waits >= TO);
    n_acc     = rej ? 0 : (abort ? TO : waits + 1);
    rv_cyc    = rej ? 1 : 2 + n_acc;
    exp_err   = rej || abort || t_slverr;
    exp_rdata = (rej || abort || t_we) ? 32'h0 : t_sdata;

    @(negedge clk);
    req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wdata;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL %s gnt: got %b expected 1", name, gnt);
    end
    @(posedge clk);
    for (int c = 1; c <= rv_cyc + 1; c++) begin
      @(negedge clk);
      req = 1'b0; we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
      fin     = !rej && !abort && (c == 1 + n_acc);
      pready  = fin ? 1'b1 : ((c == 1 || c > 1 + n_acc) ? 1'($urandom) : 1'b0);
      pslverr = fin ? t_slverr : 1'($urandom);
      prdata  = fin ? t_sdata : $urandom;
      #1;
      exp_ctl = {(!rej && c <= 1 + n_acc), (!rej && c >= 2 && c <= 1 + n_acc), (c == rv_cyc)};
      got_ctl = {apb.psel, apb.penable, rvalid};
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s psel/penable/rvalid c=%0d: got %b expected %b", name, c, got_ctl, exp_ctl);
      end
      if (exp_ctl[2]) begin
        checks++;
        if ({apb.paddr, apb.pwrite} !== {t_addr[31:2], 2'b00, t_we}) begin
          errors++;
          $display("FAIL %s paddr/pwrite c=%0d: got %h/%b expected %h/%b", name, c,
                   apb.paddr, apb.pwrite, {t_addr[31:2], 2'b00}, t_we);
        end
        if (t_we) begin
          checks++;
          if (apb.pwdata !== t_wdata) begin
            errors++;
            $display("FAIL %s pwdata c=%0d: got %h expected %h", name, c, apb.pwdata, t_wdata);
          end
        end
      end
      if (c == rv_cyc) begin
        checks++;
        if ({err, rdata} !== {exp_err, exp_rdata}) begin
          errors++;
          $display("FAIL %s response: got err=%b rdata=%h expected err=%b rdata=%h", name,
                   err, rdata, exp_err, exp_rdata);
        end
      end
      if (c == rv_cyc + 1) begin
        checks++;
        if (rdata !== exp_rdata) begin
          errors++;
          $display("FAIL %s rdata hold: got %h expected %h", name, rdata, exp_rdata);
        end
      end
    end
    pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'hF; addr = '0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, rvalid, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset ctl: got %b expected 00000", {apb.psel, apb.penable, apb.pwrite, rvalid, err});
    end
    checks++;
    if ({apb.paddr, apb.pwdata, rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset data: got paddr=%h pwdata=%h rdata=%h expected 0", apb.paddr, apb.pwdata, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_plan();
    do_txn("gpio_read", 1'b0, 4'hF, 32'h1A10_1004, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    do_txn("write_3ws", 1'b1, 4'hF, 32'h1A10_0003, 32'h0000_00A5, 3, 1'b0, 32'h5555_AAAA);
    do_txn("partial_write", 1'b1, 4'b0011, 32'h1A10_0010, 32'h1111_2222, 0, 1'b0, 32'h0);
    do_txn("slverr_read", 1'b0, 4'hF, 32'h1A10_2000, 32'h0, 1, 1'b1, 32'h0000_1234);
  endtask

  task automatic test_random();
    logic       r_we;
    logic [3:0] r_be;
    for (int i = 0; i < 16; i++) begin
      r_we = 1'($urandom);
      r_be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      do_txn("random", r_we, r_be, $urandom, $urandom, $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          ngnt;
    d = $urandom; ngnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h1A10_2008;
      end
      pready = 1'b1; pslverr = 1'b0; prdata = d;
      #1;
      checks++;
      if ({gnt, rvalid} !== {(c % 4 == 0), (c % 4 == 3)}) begin
        errors++;
        $display("FAIL b2b gnt/rvalid c=%0d: got %b expected %b", c, {gnt, rvalid},
                 {(c % 4 == 0), (c % 4 == 3)});
      end
      if (gnt) ngnt++;
      if (c % 4 == 3) begin
        checks++;
        if (rdata !== d) begin
          errors++; $display("FAIL b2b rdata c=%0d: got %h expected %h", c, rdata, d);
        end
      end
    end
    req = 1'b0; pready = 1'b0;
    checks++;
    if (ngnt != 5) begin
      errors++; $display("FAIL b2b grant count: got %0d expected 5", ngnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h1A10_3000; pready = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({apb.psel, apb.penable} !== 2'b11) begin
      errors++; $display("FAIL midrst access: got %b expected 11", {apb.psel, apb.penable});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({apb.psel, apb.penable, rvalid, apb.paddr} !== 35'h0) begin
      errors++;
      $display("FAIL midrst drop: got psel/penable/rvalid=%b paddr=%h expected 000/0",
               {apb.psel, apb.penable, rvalid}, apb.paddr);
    end
    @(negedge clk);
    rst_n = 1'b1; pready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({apb.psel, apb.penable, rvalid} !== 3'b000) begin
        errors++;
        $display("FAIL midrst quiet c=%0d: got %b expected 000", c, {apb.psel, apb.penable, rvalid});
      end
    end
    pready = 1'b0;
    do_txn("after_reset", 1'b0, 4'hF, 32'h1A10_4004, 32'h0, 1, 1'b0, 32'hCAFE_F00D);
  endtask

  task automatic test_timeout();
    if (TO_EN) begin
      do_txn("timeout", 1'b0, 4'hF, 32'h1A10_5000, 32'h0, 40, 1'b0, 32'hFFFF_FFFF);
      do_txn("after_timeout", 1'b0, 4'hF, 32'h1A10_5004, 32'h0, 0, 1'b0, 32'h0BAD_CAFE);
      do_txn("limit_ready", 1'b0, 4'hF, 32'h1A10_5008, 32'h0, TO - 1, 1'b0, 32'h7777_1234);
      do_txn("timeout_wr", 1'b1, 4'hF, 32'h1A10_500C, 32'h1234_5678, TO, 1'b0, 32'h0);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_plan();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
